// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: sequential fetch, imem req/ack, instruction FIFO, redirect flush
// Optional misaligned-redirect exception entries: define FETCH_MISALIGN_EXC_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [11:0] id_funct12,
  output logic        id_excep,
  output logic [3:0]  id_excep_code
);

  localparam int            PW      = $clog2(BUF_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   addr_q;
  logic          halt_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q    [BUF_DEPTH];

  logic          push_mem;
  logic          pop;
  logic          misalign;
  logic [31:0]   redir_pc;
  logic          fifo_push;
  logic [PW-1:0] fifo_wptr;
  logic [31:0]   fifo_instr;
  logic [31:0]   fifo_pc;
  logic [CW-1:0] count_d;
  logic          room;

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;
  assign id_valid  = (count_q != '0);
  assign push_mem  = imem_ack && (state_q == REQ);
  assign pop       = id_valid && !stall;

`ifdef FETCH_MISALIGN_EXC_EN
  assign redir_pc = redirect_pc;
  assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc = redirect_pc & ~32'h3;
  assign misalign = 1'b0;
`endif

  // A redirect empties the FIFO; a misaligned one then holds only the exception entry.
  assign fifo_push  = redirect ? misalign : push_mem;
  assign fifo_wptr  = redirect ? '0 : wr_ptr_q;
  assign fifo_instr = redirect ? NOP : imem_rdata;
  assign fifo_pc    = redirect ? redir_pc : fetch_pc_q;
  assign count_d    = redirect ? CW'(misalign) : count_q + CW'(push_mem) - CW'(pop);
  assign room       = (count_d < DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      halt_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      count_q <= count_d;
      if (redirect) begin
        fetch_pc_q <= redir_pc;
        halt_q     <= misalign;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= PW'(misalign);
        if (state_q != IDLE && !imem_ack) begin
          state_q <= DROP;
        end else if (misalign) begin
          state_q <= IDLE;
        end else begin
          state_q <= REQ;
          addr_q  <= redir_pc;
        end
      end else begin
        if (push_mem) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
        case (state_q)
          IDLE: begin
            if (room && !halt_q) begin
              state_q <= REQ;
              addr_q  <= fetch_pc_q;
            end
          end
          REQ: begin
            if (imem_ack) begin
              fetch_pc_q <= fetch_pc_q + 32'd4;
              addr_q     <= fetch_pc_q + 32'd4;
              if (!room) state_q <= IDLE;
            end
          end
          DROP: begin
            if (imem_ack) begin
              if (halt_q) begin
                state_q <= IDLE;
              end else begin
                state_q <= REQ;
                addr_q  <= fetch_pc_q;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      buf_instr_q[fifo_wptr] <= fifo_instr;
      buf_pc_q[fifo_wptr]    <= fifo_pc;
    end
  end

  assign id_instr      = id_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign id_pc         = id_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign id_opcode     = id_instr[6:0];
  assign id_funct3     = id_instr[14:12];
  assign id_funct7     = id_instr[31:25];
  assign id_funct12    = id_instr[31:20];
  assign id_excep_code = 4'd0;

`ifdef FETCH_MISALIGN_EXC_EN
  logic buf_exc_q [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (fifo_push) buf_exc_q[fifo_wptr] <= redirect;
  end

  assign id_excep = id_valid && buf_exc_q[rd_ptr_q];
`else
  assign id_excep = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit (RESET_PC=0x100, BUF_DEPTH=2)
module tb_fetch_unit;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [11:0] id_funct12;
  logic        id_excep;
  logic [3:0]  id_excep_code;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_funct12(id_funct12), .id_excep(id_excep), .id_excep_code(id_excep_code)
  );

  always #5 clk = ~clk;

  // Memory returns a word tagged by its address so each id_instr is traceable.
  assign imem_rdata = imem_addr ^ K;

  typedef struct {
    logic        ack;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic a, input logic s, input logic r, input logic [31:0] p);
    imem_ack = a; stall = s; redirect = r; redirect_pc = p;
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] ei;
    ei = v ? instr : 32'h0;
    chk({tag, " id_valid"}, 32'(id_valid), 32'(v));
    chk({tag, " id_pc"}, id_pc, v ? pc : 32'h0);
    chk({tag, " id_instr"}, id_instr, ei);
    chk({tag, " fields"}, {id_opcode, id_funct3, id_funct7, id_funct12[4:0]},
        {ei[6:0], ei[14:12], ei[31:25], ei[24:20]});
  endtask

  initial begin
    // ack, stall, redirect, redirect_pc | req, addr, valid, pc
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h100,      1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h100};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h108,      1'b1, 32'h100};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h108,      1'b1, 32'h100};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h108,      1'b1, 32'h100};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 32'h104};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10C,      1'b1, 32'h108};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10C,      1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10C,      1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h2000,     1'b1, 32'h10C,      1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10C,      1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10C,      1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2000,     1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h400,      1'b1, 32'h2004,     1'b1, 32'h2000};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h400,      1'b0, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h404,      1'b1, 32'h400};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b1, 32'h408,      1'b1, 32'h404};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h408,      1'b0, 32'h0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFF8, 1'b0, 32'h0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFF8};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFFFFFFFC};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 32'h300,      1'b1, 32'h4,        1'b0, 32'h0};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 32'h600,      1'b1, 32'h4,        1'b0, 32'h0};
    vecs[25] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0};
    vecs[26] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h600,      1'b0, 32'h0};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h604,      1'b1, 32'h600};
    vecs[28] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h604,      1'b0, 32'h0};

    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset imem_req", 32'(imem_req), 32'h0);
    chk("reset imem_addr", imem_addr, 32'h100);
    chk("reset excep", {28'h0, id_excep_code} | 32'(id_excep), 32'h0);
    chk_head("reset", 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      chk({tag, " imem_req"}, 32'(imem_req), 32'(vecs[i].e_req));
      chk({tag, " imem_addr"}, imem_addr, vecs[i].e_addr);
      chk({tag, " id_excep"}, 32'(id_excep), 32'h0);
      chk_head(tag, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_pc ^ K);
      step(vecs[i].ack, vecs[i].stl, vecs[i].rdr, vecs[i].rpc);
    end

    // Fill to full, then redirect while IDLE
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("fill1 addr", imem_addr, 32'h608);
    chk_head("fill1", 1'b1, 32'h604, 32'h604 ^ K);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("full req", 32'(imem_req), 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h800);
    chk("idle redir req", 32'(imem_req), 32'h1);
    chk("idle redir addr", imem_addr, 32'h800);
    chk_head("idle redir", 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk_head("after 800", 1'b1, 32'h800, 32'h800 ^ K);

    // Misaligned redirect while 0x804 is outstanding
    step(1'b0, 1'b0, 1'b1, 32'h402);
    chk("mis drop req", 32'(imem_req), 32'h1);
    chk("mis drop addr", imem_addr, 32'h804);
`ifdef FETCH_MISALIGN_EXC_EN
    chk("mis excep", 32'(id_excep), 32'h1);
    chk("mis code", 32'(id_excep_code), 32'h0);
    chk_head("mis", 1'b1, 32'h402, 32'h13);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis halt req", 32'(imem_req), 32'h0);
    chk_head("mis held", 1'b1, 32'h402, 32'h13);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk_head("mis popped", 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis still halted", 32'(imem_req), 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h500);
    chk("resume req", 32'(imem_req), 32'h1);
    chk("resume addr", imem_addr, 32'h500);
`else
    chk("align excep", 32'(id_excep), 32'h0);
    chk_head("align", 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("align req", 32'(imem_req), 32'h1);
    chk("align addr", imem_addr, 32'h400);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("align excep2", 32'(id_excep), 32'h0);
    chk_head("align head", 1'b1, 32'h400, 32'h400 ^ K);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
